odo_round_key_sequencer: RTL
============================

Name: odo_round_key_sequencer

Overview:
- Reader/consumer end of the Odo round-key lookup interface.
- On `start`, drives the `period` index 0..NUM_ROUNDS-1 into a registered round-key ROM (odo_get_round_keyN family, 1-cycle latency).
- Returns the keys as a valid/ready stream, with a last flag and a done pulse, to the Odo round datapath.
- Hides ROM latency and supports backpressure at full throughput: one key per cycle when `key_ready` is held high.

Parameters:
- NUM_ROUNDS, 10, number of keys per sequence; period range 0..NUM_ROUNDS-1.
- KEY_W, 10, round-key width.
- PERIOD_W, 4, width of the period/index bus; must satisfy 2^PERIOD_W >= NUM_ROUNDS.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a sequence; sampled only in IDLE.
- abort  input  1  synchronous cancel; returns to IDLE next edge.
- busy  output  1  high in PRIME and STREAM.
- period  output  PERIOD_W  index to the ROM.
- key_in  input  KEY_W  ROM output; equals ROM(period sampled at previous edge).
- key_out  output  KEY_W  current round key.
- key_index  output  PERIOD_W  round number of key_out.
- key_valid  output  1  key_out valid.
- key_ready  input  1  consumer accepts.
- key_last  output  1  key_out is round NUM_ROUNDS-1.
- done  output  1  one-cycle pulse after the last key is accepted.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, idx=0; busy, key_valid, key_last and done all 0; key_out=0; key_index=0; period=0.
- Handshake: `hs = key_valid & key_ready`.
- States:
  - IDLE: period=0, key_valid=0. When start=1 and abort=0: idx<=0, go to PRIME.
  - PRIME: exactly one cycle. period=idx=0 so the ROM latches key 0. Go to STREAM. key_valid=0.
  - STREAM: key_valid=1, key_out=key_in (pass-through; the ROM output is already registered), key_index=idx, key_last=(idx==NUM_ROUNDS-1).
- Period drive in STREAM (combinational):
  - period = idx+1 when hs and not last; otherwise period = idx.
  - This makes key_in on the next cycle correspond to the new idx, so there are no bubbles.
- Stall: while key_valid=1 and key_ready=0, idx and period hold. key_out, key_index and key_last stay stable, as required by the valid/ready rule.
- On hs and not last: idx<=idx+1, stay in STREAM.
- On hs and last: go to IDLE; done=1 for the following cycle only; idx<=0.
- Latency: start high at cycle T gives the first key_valid at T+2. With key_ready held high, the last key is presented at T+1+NUM_ROUNDS and done pulses at T+2+NUM_ROUNDS.
- start while busy: ignored; no restart, no effect on the stream.
- start in the done cycle: accepted (state is already IDLE); PRIME follows next cycle.
- abort:
  - In PRIME or STREAM: next state IDLE, key_valid=0, no done pulse, idx<=0.
  - abort has priority over hs and over start.
  - In IDLE: no effect.
- Reset asserted mid-sequence: immediate return to IDLE with reset values. No done pulse on reset release.
- idx never exceeds NUM_ROUNDS-1; there is no wrap-around beyond the sequence.
- key_valid never rises without a preceding PRIME cycle.

Test Plan:
- Bench ROM model: registered lookup of key table 0 (0:0x0b5, 1:0x0d3, 2:0x26c, 3:0x1ad, 4:0x360, 5:0x2d4, 6:0x2b2, 7:0x287, 8:0x24f, 9:0x360).
- Full-rate run: start pulse at T, key_ready=1 throughout.
  - Required: keys 0x0b5, 0x0d3, ..., 0x360 on cycles T+2..T+11.
  - key_last only at index 9; done at T+12; busy low at T+12.
- Backpressure: key_ready toggles 1,0,0,1,...
  - Required: each key held stable while ready is low.
  - Required: sequence order unchanged, no duplicates or skips; key 3 (0x1ad) is held across both stall cycles.
- Abort mid-stream: abort at index 5 (key_out=0x2d4).
  - Required: next cycle key_valid=0, busy=0, no done pulse.
  - Required: a new start restarts at 0x0b5.
- start while busy: pulse start at index 2.
  - Required: the stream continues to index 9 with exactly 10 handshakes and one done.
- Async reset: drop rst_n at index 7, off-edge.
  - Required: key_valid, busy and done go to 0 immediately.
  - Required: after release, IDLE holds with no activity until start.
- Back-to-back: start asserted in the done cycle.
  - Required: the second sequence's first key appears 2 cycles later with correct values.

Source files
------------

// File: rtl/odo_round_key_sequencer.sv
// Odo round-key sequencer: walks period 0..NUM_ROUNDS-1 through a registered
// round-key ROM and streams the keys out over valid/ready with last and done.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start, abort        begin a sequence (IDLE only) / synchronous cancel
//   busy                high while priming or streaming
//   period, key_in      ROM index out, ROM data back (1-cycle latency)
//   key_out, key_index  current round key and its round number
//   key_valid/ready     stream handshake; key_last marks the final round
//   done                one-cycle pulse after the last key is accepted
module odo_round_key_sequencer #(
  parameter int unsigned NUM_ROUNDS = 10,
  parameter int unsigned KEY_W      = 10,
  parameter int unsigned PERIOD_W   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic [PERIOD_W-1:0] period,
  input  logic [KEY_W-1:0]    key_in,
  output logic [KEY_W-1:0]    key_out,
  output logic [PERIOD_W-1:0] key_index,
  output logic                key_valid,
  input  logic                key_ready,
  output logic                key_last,
  output logic                done
);

  localparam logic [PERIOD_W-1:0] LAST_IDX = PERIOD_W'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PRIME  = 2'd1,
    S_STREAM = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [PERIOD_W-1:0]   idx_q, idx_d;
  logic                  done_q, done_d;
  logic [PERIOD_W-1:0]   period_c;
  logic                  hs_c;
  logic                  last_c;

  // State, index and done-pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic and ROM index drive
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    period_c = idx_q;
    hs_c     = (state_q == S_STREAM) && key_ready;
    last_c   = (idx_q == LAST_IDX);

    case (state_q)
      S_IDLE: begin
        period_c = '0;
        if (start && !abort) begin
          idx_d   = '0;
          state_d = S_PRIME;
        end
      end

      S_PRIME: begin
        // ROM latches key 0 this cycle so it is on key_in when STREAM begins
        if (abort) begin
          idx_d   = '0;
          state_d = S_IDLE;
        end else begin
          state_d = S_STREAM;
        end
      end

      S_STREAM: begin
        if (abort) begin
          idx_d   = '0;
          state_d = S_IDLE;
        end else if (hs_c) begin
          if (last_c) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            // Look ahead one index so the next key arrives without a bubble
            idx_d    = idx_q + PERIOD_W'(1);
            period_c = idx_q + PERIOD_W'(1);
          end
        end
      end

      default: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decode directly from registered state; key_in is already registered by the ROM
  assign period    = period_c;
  assign busy      = (state_q == S_PRIME) || (state_q == S_STREAM);
  assign key_valid = (state_q == S_STREAM);
  assign key_out   = key_valid ? key_in : '0;
  assign key_index = idx_q;
  assign key_last  = key_valid && last_c;
  assign done      = done_q;

endmodule
